// File: rtl/audio_level_pkg.sv
// rtl/audio_level_pkg.sv - shared level encoding and saturating magnitude helper
package audio_level_pkg;

    localparam int ALM_MAX_W = 32;

    typedef enum logic [1:0] {
        LVL_QUIET = 2'd0,
        LVL_MID   = 2'd1,
        LVL_LOUD  = 2'd2
    } lvl_e;

    // x is the sample sign-extended to ALM_MAX_W; result saturates to w-1 magnitude bits
    function automatic logic [ALM_MAX_W-1:0] abs_sat(input logic [ALM_MAX_W-1:0] x,
                                                     input int unsigned w);
        logic [ALM_MAX_W-1:0] mag;
        logic [ALM_MAX_W-1:0] lim;
        mag = x[ALM_MAX_W-1] ? (~x + ALM_MAX_W'(1)) : x;
        lim = (ALM_MAX_W'(1) << (w - 1)) - ALM_MAX_W'(1);
        return (mag > lim) ? lim : mag;
    endfunction

endpackage

// File: rtl/level_channel.sv
// rtl/level_channel.sv - per-channel running peak, frame peak and level FSM with hold
module level_channel
    import audio_level_pkg::*;
#(
    parameter int SAMPLE_W    = 24,
    parameter int HYST        = 16,
    parameter int HOLD_FRAMES = 4
) (
    input  logic                clk_50,
    input  logic                reset,
    input  logic                accept,
    input  logic                frame_tick,
    input  logic                eval,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [SAMPLE_W-2:0] thresh_lo,
    input  logic [SAMPLE_W-2:0] thresh_hi,
    output lvl_e                level,
    output logic [SAMPLE_W-2:0] peak
);
    localparam int MW     = SAMPLE_W - 1;
    localparam int HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

    logic [ALM_MAX_W-1:0] mag_full;
    logic [MW-1:0]        mag;
    logic                 unused_mag_hi;
    logic [MW-1:0]        hi_m, lo_m;

    logic [MW-1:0]     run_pk_d, run_pk_q;
    logic [MW-1:0]     peak_d, peak_q;
    lvl_e              level_d, level_q;
    logic [HOLD_W-1:0] hold_d, hold_q;

    assign mag_full      = abs_sat(ALM_MAX_W'($signed(sample)), SAMPLE_W);
    assign mag           = mag_full[MW-1:0];
    assign unused_mag_hi = ^mag_full[ALM_MAX_W-1:MW];

    assign hi_m = (thresh_hi >= MW'(HYST)) ? thresh_hi - MW'(HYST) : '0;
    assign lo_m = (thresh_lo >= MW'(HYST)) ? thresh_lo - MW'(HYST) : '0;

    // A sample accepted together with frame_tick seeds the new frame
    always_comb begin
        run_pk_d = run_pk_q;
        if (frame_tick)
            run_pk_d = accept ? mag : '0;
        else if (accept && (mag > run_pk_q))
            run_pk_d = mag;
        peak_d = frame_tick ? run_pk_q : peak_q;
    end

    always_comb begin
        level_d = level_q;
        hold_d  = hold_q;
        if (eval) begin
            case (level_q)
                LVL_QUIET: begin
                    if (peak_q >= thresh_hi) begin
                        level_d = LVL_LOUD;
                        hold_d  = HOLD_W'(HOLD_FRAMES);
                    end else if (peak_q >= thresh_lo) begin
                        level_d = LVL_MID;
                    end
                end
                LVL_MID: begin
                    if (peak_q >= thresh_hi) begin
                        level_d = LVL_LOUD;
                        hold_d  = HOLD_W'(HOLD_FRAMES);
                    end else if (peak_q < lo_m) begin
                        level_d = LVL_QUIET;
                    end
                end
                LVL_LOUD: begin
                    if (peak_q >= hi_m)
                        hold_d = HOLD_W'(HOLD_FRAMES);
                    else if (hold_q != '0)
                        hold_d = hold_q - HOLD_W'(1);
                    else
                        level_d = (peak_q >= lo_m) ? LVL_MID : LVL_QUIET;
                end
                default: level_d = LVL_QUIET;
            endcase
        end
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            run_pk_q <= '0;
            peak_q   <= '0;
            level_q  <= LVL_QUIET;
            hold_q   <= '0;
        end else begin
            run_pk_q <= run_pk_d;
            peak_q   <= peak_d;
            level_q  <= level_d;
            hold_q   <= hold_d;
        end
    end

    assign level = level_q;
    assign peak  = peak_q;

endmodule

// File: rtl/audio_level_meter.sv
// rtl/audio_level_meter.sv - multi-channel audio level meter top: handshake, frame pipeline, packing
module audio_level_meter
    import audio_level_pkg::*;
#(
    parameter int SAMPLE_W    = 24,
    parameter int NUM_CH      = 2,
    parameter int HYST        = 16,
    parameter int HOLD_FRAMES = 4
) (
    input  logic                         clk_50,
    input  logic                         reset,
    input  logic [NUM_CH*SAMPLE_W-1:0]   sample_in,
    input  logic                         sample_ready,
    output logic                         sample_read,
    input  logic                         frame_tick,
    input  logic [SAMPLE_W-2:0]          thresh_lo,
    input  logic [SAMPLE_W-2:0]          thresh_hi,
    output logic [2*NUM_CH-1:0]          level,
    output logic                         level_valid,
    output logic [NUM_CH*(SAMPLE_W-1)-1:0] peak
);
    logic sample_read_d, sample_read_q;
    logic eval_d, eval_q;
    logic level_valid_d, level_valid_q;

    // eval_q marks the cycle the frozen frame peak is classified
    always_comb begin
        sample_read_d = sample_ready;
        eval_d        = frame_tick;
        level_valid_d = eval_q;
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            sample_read_q <= 1'b0;
            eval_q        <= 1'b0;
            level_valid_q <= 1'b0;
        end else begin
            sample_read_q <= sample_read_d;
            eval_q        <= eval_d;
            level_valid_q <= level_valid_d;
        end
    end

    assign sample_read = sample_read_q;
    assign level_valid = level_valid_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        lvl_e ch_level;

        level_channel #(
            .SAMPLE_W    (SAMPLE_W),
            .HYST        (HYST),
            .HOLD_FRAMES (HOLD_FRAMES)
        ) u_ch (
            .clk_50     (clk_50),
            .reset      (reset),
            .accept     (sample_ready),
            .frame_tick (frame_tick),
            .eval       (eval_q),
            .sample     (sample_in[c*SAMPLE_W +: SAMPLE_W]),
            .thresh_lo  (thresh_lo),
            .thresh_hi  (thresh_hi),
            .level      (ch_level),
            .peak       (peak[c*(SAMPLE_W-1) +: (SAMPLE_W-1)])
        );

        assign level[c*2 +: 2] = ch_level;
    end

endmodule

// File: tb/tb_audio_level_meter.sv
// tb/tb_audio_level_meter.sv - directed table-driven bench for audio_level_meter
module tb_audio_level_meter;

    logic        clk_50 = 1'b0;
    logic        reset;
    logic [47:0] sample_in;
    logic        sample_ready;
    logic        sample_read;
    logic        frame_tick;
    logic [22:0] thresh_lo;
    logic [22:0] thresh_hi;
    logic [3:0]  level;
    logic        level_valid;
    logic [45:0] peak;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [1:0] Q = 2'd0, M = 2'd1, L = 2'd2;

    typedef struct packed {
        logic [2:0][23:0] s0;
        logic [23:0]      s1;
        logic [22:0]      pk0;
        logic [22:0]      pk1;
        logic [1:0]       lv0;
        logic [1:0]       lv1;
    } vec_t;

    vec_t vecs[20];

    audio_level_meter dut (
        .clk_50       (clk_50),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_ready (sample_ready),
        .sample_read  (sample_read),
        .frame_tick   (frame_tick),
        .thresh_lo    (thresh_lo),
        .thresh_hi    (thresh_hi),
        .level        (level),
        .level_valid  (level_valid),
        .peak         (peak)
    );

    always #5 clk_50 = ~clk_50;

    task automatic cyc();
        @(posedge clk_50);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [23:0] a, input logic [23:0] b,
                           input logic [23:0] c, input logic [23:0] s1,
                           input logic [22:0] pk0, input logic [22:0] pk1,
                           input logic [1:0] lv0, input logic [1:0] lv1);
        vecs[i].s0[0] = a;
        vecs[i].s0[1] = b;
        vecs[i].s0[2] = c;
        vecs[i].s1    = s1;
        vecs[i].pk0   = pk0;
        vecs[i].pk1   = pk1;
        vecs[i].lv0   = lv0;
        vecs[i].lv1   = lv1;
    endtask

    initial begin
        reset        = 1'b1;
        sample_in    = '0;
        sample_ready = 1'b0;
        frame_tick   = 1'b0;
        thresh_lo    = 23'h001000;
        thresh_hi    = 23'h008000;

        for (int i = 0; i < 3; i++) set_vec(i, 0, 0, 0, 0, 0, 0, Q, Q);
        set_vec(3, 24'h000500, 24'hFF7000, 24'h002000, 24'h001200, 23'h9000, 23'h1200, L, M);
        set_vec(4, 24'h800000, 0, 0, 0, 23'h7FFFFF, 0, L, Q);
        for (int i = 5; i < 9; i++) set_vec(i, 24'h002000, 0, 0, 0, 23'h2000, 0, L, Q);
        set_vec(9,  24'h002000, 0, 0, 0, 23'h2000, 0, M, Q);
        set_vec(10, 24'h000FF8, 0, 0, 0, 23'h0FF8, 0, M, Q);
        set_vec(11, 24'h000FEF, 0, 0, 0, 23'h0FEF, 0, Q, Q);
        set_vec(12, 24'h009000, 0, 0, 24'h000FFF, 23'h9000, 23'h0FFF, L, Q);
        set_vec(13, 24'h002000, 0, 0, 24'hFFF000, 23'h2000, 23'h1000, L, M);
        set_vec(14, 24'h007FF5, 0, 0, 24'h008000, 23'h7FF5, 23'h8000, L, L);
        for (int i = 15; i < 19; i++) set_vec(i, 0, 0, 0, 0, 0, 0, L, L);
        set_vec(19, 0, 0, 0, 0, 0, 0, Q, Q);

        cyc();
        cyc();
        reset = 1'b0;
        chk("reset sample_read", {63'd0, sample_read}, 64'd0);
        chk("reset level", {60'd0, level}, 64'd0);
        chk("reset level_valid", {63'd0, level_valid}, 64'd0);
        chk("reset peak", {18'd0, peak}, 64'd0);

        for (int v = 0; v < 20; v++) begin
            // three back-to-back samples with sample_ready held high
            for (int k = 0; k < 3; k++) begin
                sample_in    = {(k == 0) ? vecs[v].s1 : 24'd0, vecs[v].s0[k]};
                sample_ready = 1'b1;
                cyc();
                chk($sformatf("v%0d sample_read k%0d", v, k), {63'd0, sample_read}, 64'd1);
            end
            sample_ready = 1'b0;
            frame_tick   = 1'b1;
            cyc();
            frame_tick = 1'b0;
            chk($sformatf("v%0d sample_read drop", v), {63'd0, sample_read}, 64'd0);
            chk($sformatf("v%0d valid early", v), {63'd0, level_valid}, 64'd0);
            chk($sformatf("v%0d peak", v), {18'd0, peak}, {18'd0, vecs[v].pk1, vecs[v].pk0});
            cyc();
            chk($sformatf("v%0d valid", v), {63'd0, level_valid}, 64'd1);
            chk($sformatf("v%0d level", v), {60'd0, level}, {60'd0, vecs[v].lv1, vecs[v].lv0});
            cyc();
            chk($sformatf("v%0d valid late", v), {63'd0, level_valid}, 64'd0);
        end

        // sample coinciding with frame_tick belongs to the next frame
        sample_in    = {24'd0, 24'h002000};
        sample_ready = 1'b1;
        cyc();
        sample_in  = {24'd0, 24'h009000};
        frame_tick = 1'b1;
        cyc();
        sample_ready = 1'b0;
        frame_tick   = 1'b0;
        chk("coincide sample_read", {63'd0, sample_read}, 64'd1);
        chk("coincide old peak", {41'd0, peak[22:0]}, 64'h2000);
        cyc();
        chk("coincide old level", {60'd0, level}, {60'd0, Q, M});
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        chk("coincide new peak", {41'd0, peak[22:0]}, 64'h9000);
        cyc();
        chk("coincide new level", {60'd0, level}, {60'd0, Q, L});
        chk("coincide new valid", {63'd0, level_valid}, 64'd1);

        // back-to-back frame_ticks are two empty frames
        frame_tick = 1'b1;
        cyc();
        chk("double tick peak", {18'd0, peak}, 64'd0);
        cyc();
        frame_tick = 1'b0;
        chk("double tick valid1", {63'd0, level_valid}, 64'd1);
        chk("double tick level1", {60'd0, level}, {60'd0, Q, L});
        cyc();
        chk("double tick valid2", {63'd0, level_valid}, 64'd1);
        chk("double tick level2", {60'd0, level}, {60'd0, Q, L});

        // reset one cycle after frame_tick drops the pending level_valid
        cyc();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        reset      = 1'b1;
        cyc();
        reset = 1'b0;
        chk("midreset valid", {63'd0, level_valid}, 64'd0);
        chk("midreset level", {60'd0, level}, 64'd0);
        chk("midreset peak", {18'd0, peak}, 64'd0);
        cyc();
        chk("midreset valid later", {63'd0, level_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
